reg_rename_file: RTL and testbench
==================================

// Module: reg_rename_file
// PURPOSE
// - Architectural register file plus per-register rename tags: the consumer of the ROB's issue and
//   commit streams and the initiator of the ROB operand-lookup ports (get_rob_entry1/2).
// - Tells the decoder each source operand's value, or the ROB entry that will produce it.
// - Sits between the decoder (operand read), the ROB (issue/commit/lookup) and the RS/LSB dispatch.
// PARAMETERS
// - REG_NUM   32         architectural registers; x0 is hardwired to zero.
// - REG_BIT   `REG_BIT   register index width (5).
// - ROB_BIT   `ROB_BIT   ROB entry tag width.
// PORTS
// - clk_in            in   1        system clock
// - rst_in            in   1        synchronous, active-high reset
// - rdy_in            in   1        low = freeze all state; combinational outputs stay valid
// - clear_up          in   1        mispredict flush from the ROB
// - issue_valid       in   1        decoder issues an instruction that writes rd this cycle
// - issue_reg_id      in   REG_BIT  rd of the issuing instruction
// - issue_rob_entry   in   ROB_BIT  ROB tag allocated to it
// - rob_commit        in   1        ROB retires a register-writing entry
// - commit_rd_reg_id  in   REG_BIT  rd of the retiring entry
// - commit_rob_entry  in   ROB_BIT  tag of the retiring entry
// - commit_value      in   32       result of the retiring entry
// - rs1_id, rs2_id    in   REG_BIT  decoder source indices
// - get_rob_entry1/2  out  ROB_BIT  tag of rs1/rs2, sent to the ROB lookup ports
// - ready1/2          in   1        ROB reports the looked-up tag as having a result
// - value1/2          in   32       ROB-supplied value for that tag
// - rs1_dep/rs2_dep   out  1        1 = operand still pending; use rs*_tag
// - rs1_tag/rs2_tag   out  ROB_BIT  producing ROB entry when the matching rs*_dep is 1
// - rs1_val/rs2_val   out  32       operand value when the matching rs*_dep is 0
// BEHAVIOUR
// - State: regs[REG_NUM] (32b each), busy[REG_NUM], tag[REG_NUM] (ROB_BIT each).
// - Reset: all regs = 0, busy = 0, tag = 0. While reset is asserted, outputs read 0 / dep = 0.
// - Read path (combinational, zero latency), per operand with index i:
//   - i == 0: val 0, dep 0.
//   - !busy[i]: val regs[i], dep 0.
//   - busy[i], and this cycle commits tag[i] to reg i: val commit_value, dep 0.
//   - busy[i], otherwise ready1/2: val value1/2, dep 0.
//   - else: dep 1, tag tag[i], val 0.
//   - get_rob_entry1/2 is always tag[rs1_id]/tag[rs2_id].
// - Reads see pre-issue state: an instruction's own rd issue never renames its own sources
//   (add x1,x1,x2 reads the old x1 mapping).
// - Commit (posedge, rdy_in=1, rob_commit=1, rd!=0): regs[rd] <= commit_value.
//   Clear busy[rd] only if busy[rd] && tag[rd]==commit_rob_entry; a younger rename survives.
// - Issue (posedge, rdy_in=1, issue_valid=1, rd!=0): busy[rd] <= 1, tag[rd] <= issue_rob_entry.
// - Issue and commit to the same rd in the same cycle: the regs write happens; issue wins busy/tag.
// - clear_up && rdy_in: clear all busy bits. The commit in the same cycle still writes regs.
//   Any issue that cycle is dropped.
// - rd==0 writes and renames are ignored. Reset takes priority over everything.
// - rdy_in=0: no state changes.
// STRUCTURE
// - Const.v holds REG_BIT, ROB_BIT, ROB_SIZE.
// - One natural sub-module: operand_resolve, the combinational per-operand mux, instantiated twice.
// - Expected implementation size: ~150-220 lines.
// TESTING
// - Reset, then read x5/x0 -> val 0, dep 0; issue x0 tag 3 -> x0 stays dep 0, val 0.
// - Issue x5 tag 2, ready1=0 -> next cycle rs1_id=5 gives dep 1, tag 2. Commit x5 tag 2 value
//   0xDEAD -> same-cycle read val 0xDEAD, dep 0; next cycle busy clear, regs[5] = 0xDEAD.
// - Issue x7 tag 1, then issue x7 tag 4, then commit x7 tag 1 value 9 -> regs[7] = 9, still
//   dep 1 with tag 4.
// - Same cycle: commit x8 tag 6 value 0x11 and issue x8 tag 7 -> regs[8] = 0x11, busy,
//   tag 7; a read that cycle returns 0x11.
// - x3 busy tag 5, ROB ready1=1, value1=0x42 -> rs1 val 0x42, dep 0, get_rob_entry1 = 5.
// - x2/x9 busy, clear_up=1 with issue x4 -> all busy 0, x4 not renamed; rdy_in=0 holds state.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_rename_file_pkg
// Shared sizing constants for the architectural register file / rename table
// and the operand-resolve helper.
//   REG_NUM  : number of architectural registers (x0 hardwired to zero)
//   REG_BIT  : register index width
//   ROB_BIT  : ROB entry tag width
//   ROB_SIZE : number of ROB entries addressable by a tag
//   XLEN     : data width of a register
// -----------------------------------------------------------------------------
package reg_rename_file_pkg;

    localparam int REG_NUM  = 32;
    localparam int REG_BIT  = 5;
    localparam int ROB_BIT  = 4;
    localparam int ROB_SIZE = 1 << ROB_BIT;
    localparam int XLEN     = 32;

    typedef logic [REG_BIT-1:0] reg_id_t;
    typedef logic [ROB_BIT-1:0] rob_tag_t;
    typedef logic [XLEN-1:0]    word_t;

endpackage : reg_rename_file_pkg

// File: rtl/reg_rename_file_operand_resolve.sv
// -----------------------------------------------------------------------------
// reg_rename_file_operand_resolve
// Combinational per-operand mux: decides whether a source operand is already
// available (register file, same-cycle commit, or ROB lookup result) or is
// still waiting on a ROB entry.
// Ports:
//   rst_i          : forces an all-zero, non-dependent answer while in reset
//   idx_i          : source register index
//   busy_i, tag_i  : rename state of that register
//   reg_val_i      : architectural value of that register
//   commit_*_i     : retirement happening this cycle (bypass source)
//   ready_i        : ROB reports the looked-up tag has a result
//   rob_val_i      : ROB-supplied value for that tag
//   dep_o          : 1 = operand pending, consume tag_o
//   tag_o          : producing ROB entry when dep_o = 1, else 0
//   val_o          : operand value when dep_o = 0, else 0
// -----------------------------------------------------------------------------
module reg_rename_file_operand_resolve
    import reg_rename_file_pkg::*;
(
    input  logic     rst_i,
    input  reg_id_t  idx_i,
    input  logic     busy_i,
    input  rob_tag_t tag_i,
    input  word_t    reg_val_i,
    input  logic     commit_valid_i,
    input  reg_id_t  commit_rd_i,
    input  rob_tag_t commit_tag_i,
    input  word_t    commit_val_i,
    input  logic     ready_i,
    input  word_t    rob_val_i,
    output logic     dep_o,
    output rob_tag_t tag_o,
    output word_t    val_o
);

    logic commit_hit_s;

    // The retiring entry is exactly the one this register is waiting on.
    assign commit_hit_s = commit_valid_i && (commit_rd_i == idx_i) && (commit_tag_i == tag_i);

    // Priority mux: x0, clean register, same-cycle commit bypass, ROB result, pending.
    always_comb begin
        dep_o = 1'b0;
        tag_o = '0;
        val_o = '0;
        if (rst_i) begin
            val_o = '0;
        end else if (idx_i == reg_id_t'(0)) begin
            val_o = '0;
        end else if (!busy_i) begin
            val_o = reg_val_i;
        end else if (commit_hit_s) begin
            val_o = commit_val_i;
        end else if (ready_i) begin
            val_o = rob_val_i;
        end else begin
            dep_o = 1'b1;
            tag_o = tag_i;
        end
    end

endmodule : reg_rename_file_operand_resolve

// File: rtl/reg_rename_file.sv
// -----------------------------------------------------------------------------
// reg_rename_file
// Architectural register file with per-register rename tags. Consumes the
// ROB issue/commit streams, drives the ROB operand-lookup tags and returns
// resolved operands (value or producing ROB tag) to the decoder.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (0 = freeze state)
//   clear_up                      : mispredict flush, drops all renames
//   issue_valid/_reg_id/_rob_entry: rename rd to a new ROB tag
//   rob_commit/commit_rd_reg_id/commit_rob_entry/commit_value: retirement
//   rs1_id, rs2_id                : decoder source indices
//   get_rob_entry1/2              : tag of rs1/rs2 sent to the ROB lookup
//   ready1/2, value1/2            : ROB lookup answer
//   rs*_dep, rs*_tag, rs*_val     : resolved operand
// -----------------------------------------------------------------------------
module reg_rename_file
    import reg_rename_file_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_up,
    input  logic               issue_valid,
    input  logic [REG_BIT-1:0] issue_reg_id,
    input  logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic               rob_commit,
    input  logic [REG_BIT-1:0] commit_rd_reg_id,
    input  logic [ROB_BIT-1:0] commit_rob_entry,
    input  logic [31:0]        commit_value,
    input  logic [REG_BIT-1:0] rs1_id,
    input  logic [REG_BIT-1:0] rs2_id,
    output logic [ROB_BIT-1:0] get_rob_entry1,
    output logic [ROB_BIT-1:0] get_rob_entry2,
    input  logic               ready1,
    input  logic               ready2,
    input  logic [31:0]        value1,
    input  logic [31:0]        value2,
    output logic               rs1_dep,
    output logic               rs2_dep,
    output logic [ROB_BIT-1:0] rs1_tag,
    output logic [ROB_BIT-1:0] rs2_tag,
    output logic [31:0]        rs1_val,
    output logic [31:0]        rs2_val
);

    word_t              regs_q [REG_NUM];
    word_t              regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    rob_tag_t           tag_q  [REG_NUM];
    rob_tag_t           tag_d  [REG_NUM];

    logic commit_ok_s;
    logic issue_ok_s;

    // Writes aimed at x0 are discarded at the source.
    assign commit_ok_s = rob_commit  && (commit_rd_reg_id != reg_id_t'(0));
    assign issue_ok_s  = issue_valid && (issue_reg_id     != reg_id_t'(0));

    // Next-state: commit first, then flush or issue so a same-cycle rename wins busy/tag.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy_in) begin
            if (commit_ok_s) begin
                regs_d[commit_rd_reg_id] = commit_value;
                // Only the newest rename may clear busy; an older commit leaves a younger rename alone.
                if (busy_q[commit_rd_reg_id] && (tag_q[commit_rd_reg_id] == commit_rob_entry)) begin
                    busy_d[commit_rd_reg_id] = 1'b0;
                end else begin
                    busy_d[commit_rd_reg_id] = busy_q[commit_rd_reg_id];
                end
            end else begin
                busy_d = busy_q;
            end
            if (clear_up) begin
                busy_d = '0;
            end else if (issue_ok_s) begin
                busy_d[issue_reg_id] = 1'b1;
                tag_d[issue_reg_id]  = issue_rob_entry;
            end else begin
                tag_d = tag_d;
            end
        end else begin
            busy_d = busy_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= regs_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    // ROB lookup tags follow the rename table; quiet while in reset.
    assign get_rob_entry1 = rst_in ? rob_tag_t'(0) : tag_q[rs1_id];
    assign get_rob_entry2 = rst_in ? rob_tag_t'(0) : tag_q[rs2_id];

    reg_rename_file_operand_resolve u_resolve_rs1 (
        .rst_i          (rst_in),
        .idx_i          (rs1_id),
        .busy_i         (busy_q[rs1_id]),
        .tag_i          (tag_q[rs1_id]),
        .reg_val_i      (regs_q[rs1_id]),
        .commit_valid_i (rob_commit),
        .commit_rd_i    (commit_rd_reg_id),
        .commit_tag_i   (commit_rob_entry),
        .commit_val_i   (commit_value),
        .ready_i        (ready1),
        .rob_val_i      (value1),
        .dep_o          (rs1_dep),
        .tag_o          (rs1_tag),
        .val_o          (rs1_val)
    );

    reg_rename_file_operand_resolve u_resolve_rs2 (
        .rst_i          (rst_in),
        .idx_i          (rs2_id),
        .busy_i         (busy_q[rs2_id]),
        .tag_i          (tag_q[rs2_id]),
        .reg_val_i      (regs_q[rs2_id]),
        .commit_valid_i (rob_commit),
        .commit_rd_i    (commit_rd_reg_id),
        .commit_tag_i   (commit_rob_entry),
        .commit_val_i   (commit_value),
        .ready_i        (ready2),
        .rob_val_i      (value2),
        .dep_o          (rs2_dep),
        .tag_o          (rs2_tag),
        .val_o          (rs2_val)
    );

endmodule : reg_rename_file

// File: tb/tb_reg_rename_file.sv
// -----------------------------------------------------------------------------
// tb_reg_rename_file
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a behavioural register/rename model held in plain arrays.
// -----------------------------------------------------------------------------
module tb_reg_rename_file;
    import reg_rename_file_pkg::*;

    logic               clk_in = 1'b0;
    logic               rst_in, rdy_in, clear_up;
    logic               issue_valid;
    logic [REG_BIT-1:0] issue_reg_id;
    logic [ROB_BIT-1:0] issue_rob_entry;
    logic               rob_commit;
    logic [REG_BIT-1:0] commit_rd_reg_id;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic [31:0]        commit_value;
    logic [REG_BIT-1:0] rs1_id, rs2_id;
    logic [ROB_BIT-1:0] get_rob_entry1, get_rob_entry2;
    logic               ready1, ready2;
    logic [31:0]        value1, value2;
    logic               rs1_dep, rs2_dep;
    logic [ROB_BIT-1:0] rs1_tag, rs2_tag;
    logic [31:0]        rs1_val, rs2_val;

    reg_rename_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_up(clear_up),
        .issue_valid(issue_valid), .issue_reg_id(issue_reg_id), .issue_rob_entry(issue_rob_entry),
        .rob_commit(rob_commit), .commit_rd_reg_id(commit_rd_reg_id),
        .commit_rob_entry(commit_rob_entry), .commit_value(commit_value),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
        .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
        .rs1_dep(rs1_dep), .rs2_dep(rs2_dep), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_val(rs1_val), .rs2_val(rs2_val)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: architectural state as the decoder should perceive it.
    logic [31:0]        m_regs [32];
    logic               m_busy [32];
    logic [ROB_BIT-1:0] m_tag  [32];

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // What the decoder should see for one source operand this cycle.
    task automatic expect_operand(input int idx, input logic rdy_hit, input logic [31:0] rob_v,
                                  output logic dep, output logic [31:0] val, output logic [ROB_BIT-1:0] tg);
        dep = 1'b0; val = 32'd0; tg = '0;
        if (rst_in || idx == 0) begin
            val = 32'd0;
        end else if (!m_busy[idx]) begin
            val = m_regs[idx];
        end else if (rob_commit && int'(commit_rd_reg_id) == idx && commit_rob_entry == m_tag[idx]) begin
            val = commit_value;
        end else if (rdy_hit) begin
            val = rob_v;
        end else begin
            dep = 1'b1;
            tg  = m_tag[idx];
        end
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clear_up = 1'b0;
        issue_valid = 1'b0; issue_reg_id = '0; issue_rob_entry = '0;
        rob_commit = 1'b0; commit_rd_reg_id = '0; commit_rob_entry = '0; commit_value = 32'd0;
        rs1_id = '0; rs2_id = '0; ready1 = 1'b0; ready2 = 1'b0; value1 = 32'd0; value2 = 32'd0;
    endtask

    // Check combinational outputs against the model, then advance model and DUT one clock.
    task automatic tick();
        logic dep; logic [31:0] val; logic [ROB_BIT-1:0] tg;
        int rd;
        #1;
        expect_operand(int'(rs1_id), ready1, value1, dep, val, tg);
        chk("rs1_dep", {31'd0, rs1_dep}, {31'd0, dep});
        chk("rs1_val", rs1_val, val);
        if (dep) chk("rs1_tag", {28'd0, rs1_tag}, {28'd0, tg});
        chk("get_rob_entry1", {28'd0, get_rob_entry1}, rst_in ? 32'd0 : {28'd0, m_tag[rs1_id]});
        expect_operand(int'(rs2_id), ready2, value2, dep, val, tg);
        chk("rs2_dep", {31'd0, rs2_dep}, {31'd0, dep});
        chk("rs2_val", rs2_val, val);
        if (dep) chk("rs2_tag", {28'd0, rs2_tag}, {28'd0, tg});
        chk("get_rob_entry2", {28'd0, get_rob_entry2}, rst_in ? 32'd0 : {28'd0, m_tag[rs2_id]});
        // State update per the behavioural rules.
        if (rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            rd = int'(commit_rd_reg_id);
            if (rob_commit && rd != 0) begin
                m_regs[rd] = commit_value;
                if (m_busy[rd] && m_tag[rd] == commit_rob_entry) m_busy[rd] = 1'b0;
            end
            if (clear_up) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (issue_valid && issue_reg_id != '0) begin
                m_busy[issue_reg_id] = 1'b1;
                m_tag[issue_reg_id]  = issue_rob_entry;
            end
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        model_reset();
        idle();
        rst_in = 1'b1;
        @(negedge clk_in);
        rs1_id = 5'd5; rs2_id = 5'd9;
        tick();
        tick();
        chk("reset_rs1_val", rs1_val, 32'd0);

        // x0 read and rename of x0.
        idle(); rs1_id = 5'd5; rs2_id = 5'd0; tick();
        issue_valid = 1'b1; issue_reg_id = 5'd0; issue_rob_entry = 4'd3; tick();
        idle(); rs1_id = 5'd0; tick();
        chk("x0_dep", {31'd0, rs1_dep}, 32'd0);

        // Rename x5 to tag 2, then commit it.
        idle(); issue_valid = 1'b1; issue_reg_id = 5'd5; issue_rob_entry = 4'd2; tick();
        idle(); rs1_id = 5'd5; #1;
        chk("x5_dep", {31'd0, rs1_dep}, 32'd1);
        chk("x5_tag", {28'd0, rs1_tag}, 32'd2);
        tick();
        rob_commit = 1'b1; commit_rd_reg_id = 5'd5; commit_rob_entry = 4'd2;
        commit_value = 32'hDEAD; rs1_id = 5'd5; #1;
        chk("x5_bypass", rs1_val, 32'hDEAD);
        tick();
        idle(); rs1_id = 5'd5; #1;
        chk("x5_after", rs1_val, 32'hDEAD);
        tick();

        // Younger rename survives an older commit.
        idle(); issue_valid = 1'b1; issue_reg_id = 5'd7; issue_rob_entry = 4'd1; tick();
        issue_rob_entry = 4'd4; tick();
        idle(); rob_commit = 1'b1; commit_rd_reg_id = 5'd7; commit_rob_entry = 4'd1;
        commit_value = 32'd9; tick();
        idle(); rs1_id = 5'd7; #1;
        chk("x7_dep", {31'd0, rs1_dep}, 32'd1);
        chk("x7_tag", {28'd0, rs1_tag}, 32'd4);
        tick();

        // Same-cycle commit and issue on x8.
        idle(); issue_valid = 1'b1; issue_reg_id = 5'd8; issue_rob_entry = 4'd6; tick();
        idle(); rob_commit = 1'b1; commit_rd_reg_id = 5'd8; commit_rob_entry = 4'd6;
        commit_value = 32'h11; issue_valid = 1'b1; issue_reg_id = 5'd8; issue_rob_entry = 4'd7;
        rs1_id = 5'd8; #1;
        chk("x8_bypass", rs1_val, 32'h11);
        tick();
        idle(); rs1_id = 5'd8; ready1 = 1'b0; #1;
        chk("x8_tag", {28'd0, rs1_tag}, 32'd7);
        tick();

        // ROB lookup supplies the value.
        idle(); issue_valid = 1'b1; issue_reg_id = 5'd3; issue_rob_entry = 4'd5; tick();
        idle(); rs1_id = 5'd3; ready1 = 1'b1; value1 = 32'h42; #1;
        chk("x3_rob_val", rs1_val, 32'h42);
        chk("x3_lookup", {28'd0, get_rob_entry1}, 32'd5);
        tick();

        // Flush drops renames and a same-cycle issue; frozen cycle holds state.
        idle(); issue_valid = 1'b1; issue_reg_id = 5'd2; issue_rob_entry = 4'd8; tick();
        issue_reg_id = 5'd9; issue_rob_entry = 4'd9; tick();
        idle(); clear_up = 1'b1; issue_valid = 1'b1; issue_reg_id = 5'd4; issue_rob_entry = 4'd10; tick();
        idle(); rs1_id = 5'd4; rs2_id = 5'd9; tick();
        rdy_in = 1'b0; issue_valid = 1'b1; issue_reg_id = 5'd6; issue_rob_entry = 4'd11;
        rob_commit = 1'b1; commit_rd_reg_id = 5'd6; commit_value = 32'h77; tick();
        idle(); rs1_id = 5'd6; rs2_id = 5'd2; tick();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int rd;
            idle();
            rst_in   = ($urandom_range(0, 199) == 0);
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_up = ($urandom_range(0, 19) == 0);
            issue_valid     = $urandom_range(0, 1) == 1;
            issue_reg_id    = REG_BIT'($urandom_range(0, 31));
            issue_rob_entry = ROB_BIT'($urandom_range(0, ROB_SIZE - 1));
            rob_commit       = $urandom_range(0, 1) == 1;
            rd               = $urandom_range(0, 31);
            commit_rd_reg_id = REG_BIT'(rd);
            commit_rob_entry = ($urandom_range(0, 2) != 0) ? m_tag[rd]
                                                           : ROB_BIT'($urandom_range(0, ROB_SIZE - 1));
            commit_value     = $urandom;
            rs1_id = ($urandom_range(0, 1) == 1) ? REG_BIT'(rd) : REG_BIT'($urandom_range(0, 31));
            rs2_id = REG_BIT'($urandom_range(0, 31));
            ready1 = ($urandom_range(0, 3) == 0); value1 = $urandom;
            ready2 = ($urandom_range(0, 3) == 0); value2 = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_reg_rename_file
